// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl
//
// Initiator side of the multiply/divide handshake in the execute stage.
// Accepts HI/LO-class instructions from the pipeline, launches the mul/div
// unit with registered operands and a held start request, captures the
// 64-bit result into the architectural HI/LO registers, and stalls the
// pipeline until each operation has finished.
//
// Parameters:
//   MUL_LAT  cycles md_start is held for a multiply before sampling (>= 1)
//   TIMEOUT  maximum cycles spent waiting on a divide before abandoning it
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   op_valid, op       pipeline request and its 3-bit HI/LO opcode
//   rs_val, rt_val     operands (rs_val is also the MTHI/MTLO data)
//   stall              combinational pipeline hold
//   hi, lo             architectural HI/LO registers
//   md_err             sticky divide-timeout flag
//   md_start           registered request to the mul/div unit
//   md_div_mul         registered operation select {multiply, unsigned}
//   md_a, md_b         registered operands to the unit
//   md_hi, md_lo       result words from the unit
//   md_busy            unit busy, meaningful only while md_start is high

module md_issue_ctrl #(
  parameter int MUL_LAT = 1,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_err,
  output logic        md_start,
  output logic [1:0]  md_div_mul,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_lo,
  input  logic [31:0] md_hi,
  input  logic        md_busy
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    MUL_WAIT,
    DIV_ARM,
    DIV_WAIT
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;

  logic       launch;
  logic [1:0] launch_sel;
  logic       finish;
  logic       capture;
  logic       set_err;
  logic       wr_hi;
  logic       wr_lo;
  logic       cnt_clr;
  logic       cnt_inc;

  // Next-state and control decode. Only IDLE looks at op; in every other
  // state the presented instruction is the one already in flight.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    launch     = 1'b0;
    launch_sel = 2'b00;
    finish     = 1'b0;
    capture    = 1'b0;
    set_err    = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;

    case (state)
      IDLE: begin
        if (op_valid) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              launch     = 1'b1;
              launch_sel = (op == OP_MULTU) ? 2'b11 : 2'b10;
              stall      = 1'b1;
              cnt_clr    = 1'b1;
              next_state = MUL_WAIT;
            end
            OP_DIV, OP_DIVU: begin
              launch     = 1'b1;
              launch_sel = (op == OP_DIVU) ? 2'b01 : 2'b00;
              stall      = 1'b1;
              cnt_clr    = 1'b1;
              next_state = DIV_ARM;
            end
            OP_MTHI: wr_hi = 1'b1;
            OP_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end

      MUL_WAIT: begin
        if (cnt == MUL_LAST) begin
          capture    = 1'b1;
          finish     = 1'b1;
          next_state = IDLE;
        end else begin
          stall   = 1'b1;
          cnt_inc = 1'b1;
        end
      end

      // The unit's busy flag is not yet valid on the first start cycle,
      // so this state simply waits one cycle before looking at it.
      DIV_ARM: begin
        stall      = 1'b1;
        cnt_clr    = 1'b1;
        next_state = DIV_WAIT;
      end

      // Completion takes priority over the timeout on the same cycle.
      DIV_WAIT: begin
        if (!md_busy) begin
          capture    = 1'b1;
          finish     = 1'b1;
          next_state = IDLE;
        end else if (cnt == TO_LAST) begin
          set_err    = 1'b1;
          finish     = 1'b1;
          next_state = IDLE;
        end else begin
          stall   = 1'b1;
          cnt_inc = 1'b1;
        end
      end

      default: next_state = IDLE;
    endcase

    if (rst) begin
      stall = 1'b0;
    end
  end

  // State, counter and unit request registers. The operands and select are
  // only written on launch, so they stay stable through the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      md_start   <= 1'b0;
      md_div_mul <= 2'b00;
      md_a       <= '0;
      md_b       <= '0;
    end else begin
      state <= next_state;

      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end

      if (launch) begin
        md_start   <= 1'b1;
        md_div_mul <= launch_sel;
        md_a       <= rs_val;
        md_b       <= rt_val;
      end else if (finish) begin
        md_start <= 1'b0;
      end
    end
  end

  // Architectural HI/LO and the sticky error flag. A reset edge clears
  // them and suppresses any capture that would have happened.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      md_err <= 1'b0;
    end else begin
      if (capture) begin
        hi <= md_hi;
        lo <= md_lo;
      end else begin
        if (wr_hi) begin
          hi <= rs_val;
        end
        if (wr_lo) begin
          lo <= rs_val;
        end
      end

      if (set_err) begin
        md_err <= 1'b1;
      end
    end
  end

endmodule
